// File: rtl/display_render_pkg.sv
// Shared constants for the display renderer: colours, screen/border edges and paddle row.
// Flash state encodings are used only when DISPLAY_RENDER_FLASH_EN is defined.
package display_render_pkg;

   typedef logic [2:0] colour_t;

   localparam colour_t COLOUR_BLACK = 3'b000;
   localparam colour_t COLOUR_WHITE = 3'b111;
   localparam colour_t COLOUR_RED   = 3'b100;
   localparam colour_t COLOUR_GREEN = 3'b010;

   // Visible area is 0..SCREEN_RIGHT x 0..SCREEN_BOTTOM; the bottom edge has no border
   localparam int SCREEN_RIGHT  = 639;
   localparam int SCREEN_BOTTOM = 479;
   localparam int BORDER_LEFT   = 8;
   localparam int BORDER_RIGHT  = 631;
   localparam int BORDER_TOP    = 8;

   localparam int PLAYER_VSTART = 440;
   localparam int PLAYER_WIDTH  = 8;

   localparam logic [1:0] FLASH_OFF  = 2'd0;
   localparam logic [1:0] FLASH_DARK = 2'd1;
   localparam logic [1:0] FLASH_LIT  = 2'd2;

endpackage

// File: rtl/display_render_flash_ctrl.sv
// Win/lose colour source. With DISPLAY_RENDER_FLASH_EN the colour blinks every three
// frames (counted on vsync falling edges); without it the colour is solid.
module flash_ctrl
   import display_render_pkg::*;
(
   input  logic    clk,
   input  logic    reset_n,
   input  logic    vsync,
   input  logic    win,
   input  logic    lose,
   output colour_t flash_rgb,
   output logic    active
);

   assign active = win | lose;

`ifdef DISPLAY_RENDER_FLASH_EN
   logic       vsync_q;
   logic       frame_tick;
   logic [2:0] frame_cnt;
   logic [2:0] cnt_next;
   logic [2:0] cnt_d;
   logic [1:0] state;
   logic [1:0] state_d;

   assign frame_tick = vsync_q & ~vsync;
   assign cnt_next   = frame_cnt + {2'b00, frame_tick};

   // Transitions look at the post-increment count so state and counter switch together
   always_comb begin
      state_d = state;
      cnt_d   = cnt_next;
      case (state)
         FLASH_OFF: begin
            cnt_d = 3'd0;
            if (active) state_d = FLASH_DARK;
         end
         FLASH_DARK: begin
            if (cnt_next == 3'd3) state_d = FLASH_LIT;
         end
         FLASH_LIT: begin
            if (cnt_next == 3'd6) begin
               state_d = FLASH_DARK;
               cnt_d   = 3'd0;
            end
         end
         default: begin
            state_d = FLASH_OFF;
            cnt_d   = 3'd0;
         end
      endcase
      if (!active) begin
         state_d = FLASH_OFF;
         cnt_d   = 3'd0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vsync_q   <= 1'b0;
         frame_cnt <= 3'd0;
         state     <= FLASH_OFF;
      end else begin
         vsync_q   <= vsync;
         frame_cnt <= cnt_d;
         state     <= state_d;
      end
   end

   assign flash_rgb = (state == FLASH_LIT) ? (win ? COLOUR_WHITE : COLOUR_RED) : COLOUR_BLACK;
`else
   logic unused_flash;
   assign unused_flash = ^{clk, reset_n, vsync};
   assign flash_rgb    = win ? COLOUR_WHITE : COLOUR_RED;
`endif

endmodule

// File: rtl/display_render.sv
// Two-stage pixel renderer: stage 1 registers all hit tests, stage 2 the resolved colour.
// Optional blinking win/lose screen is enabled with DISPLAY_RENDER_FLASH_EN.
module display_render
   import display_render_pkg::*;
#(
   parameter int N_BALLS  = 3,
   parameter int N_BLOCKS = 13,
   parameter int BALL_R2  = 16,
   parameter int CW       = 10
)(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [CW-1:0]         hcount,
   input  logic [CW-1:0]         vcount,
   input  logic                  vsync,
   input  logic [N_BALLS*CW-1:0] ball_x,
   input  logic [N_BALLS*CW-1:0] ball_y,
   input  logic [CW-1:0]         left_position,
   input  logic [CW-1:0]         right_position,
   input  logic                  blk_wr,
   input  logic [4:0]            blk_idx,
   input  logic [CW-1:0]         blk_x0,
   input  logic [CW-1:0]         blk_x1,
   input  logic [CW-1:0]         blk_y0,
   input  logic [CW-1:0]         blk_y1,
   input  logic [N_BLOCKS-1:0]   block_to_del,
   input  logic                  win,
   input  logic                  lose,
   output logic [2:0]            rgb,
   output logic                  player_en,
   output logic [N_BLOCKS-1:0]   block_en
);

   localparam logic [CW-1:0] SCR_R   = CW'(SCREEN_RIGHT);
   localparam logic [CW-1:0] SCR_B   = CW'(SCREEN_BOTTOM);
   localparam logic [CW-1:0] BRD_L   = CW'(BORDER_LEFT);
   localparam logic [CW-1:0] BRD_R   = CW'(BORDER_RIGHT);
   localparam logic [CW-1:0] BRD_T   = CW'(BORDER_TOP);
   localparam logic [CW-1:0] PAD_TOP = CW'(PLAYER_VSTART);
   localparam logic [CW-1:0] PAD_BOT = CW'(PLAYER_VSTART + PLAYER_WIDTH);
   localparam logic signed [2*CW+2:0] R2 = (2*CW+3)'(BALL_R2);

   logic [CW-1:0] tbl_x0 [N_BLOCKS];
   logic [CW-1:0] tbl_x1 [N_BLOCKS];
   logic [CW-1:0] tbl_y0 [N_BLOCKS];
   logic [CW-1:0] tbl_y1 [N_BLOCKS];

   colour_t flash_rgb;
   logic    flash_active;

   logic                     ball_hit;
   logic [N_BLOCKS-1:0]      blk_live;
   logic signed [CW:0]       dx;
   logic signed [CW:0]       dy;
   logic signed [2*CW+2:0]   dxe;
   logic signed [2*CW+2:0]   dye;
   logic signed [2*CW+2:0]   dist2;

   logic                s1_off;
   logic                s1_flash;
   colour_t             s1_flash_rgb;
   logic                s1_border;
   logic                s1_ball;
   logic                s1_paddle;
   logic [N_BLOCKS-1:0] s1_live;

   logic [2:0]          rgb_d;
   logic                player_d;
   logic [N_BLOCKS-1:0] block_d;

   flash_ctrl u_flash (
      .clk       (clk),
      .reset_n   (reset_n),
      .vsync     (vsync),
      .win       (win),
      .lose      (lose),
      .flash_rgb (flash_rgb),
      .active    (flash_active)
   );

   // Indices at or above N_BLOCKS match no slot, so such writes drop out naturally
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_BLOCKS; i++) begin
            tbl_x0[i] <= '0;
            tbl_x1[i] <= '0;
            tbl_y0[i] <= '0;
            tbl_y1[i] <= '0;
         end
      end else if (blk_wr) begin
         for (int i = 0; i < N_BLOCKS; i++) begin
            if (blk_idx == 5'(i)) begin
               tbl_x0[i] <= blk_x0;
               tbl_x1[i] <= blk_x1;
               tbl_y0[i] <= blk_y0;
               tbl_y1[i] <= blk_y1;
            end
         end
      end
   end

   // Differences are one bit wider and signed, squares sized so the sum never wraps
   always_comb begin
      ball_hit = 1'b0;
      dx       = '0;
      dy       = '0;
      dxe      = '0;
      dye      = '0;
      dist2    = '0;
      for (int i = 0; i < N_BALLS; i++) begin
         dx    = $signed({1'b0, hcount}) - $signed({1'b0, ball_x[i*CW +: CW]});
         dy    = $signed({1'b0, vcount}) - $signed({1'b0, ball_y[i*CW +: CW]});
         dxe   = {{(CW+2){dx[CW]}}, dx};
         dye   = {{(CW+2){dy[CW]}}, dy};
         dist2 = dxe * dxe + dye * dye;
         if (dist2 < R2) ball_hit = 1'b1;
      end
   end

   always_comb begin
      blk_live = '0;
      for (int i = 0; i < N_BLOCKS; i++) begin
         blk_live[i] = (tbl_y0[i] < vcount) && (vcount < tbl_y1[i]) &&
                       (tbl_x0[i] < hcount) && (hcount < tbl_x1[i]) &&
                       !block_to_del[i];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_off       <= 1'b0;
         s1_flash     <= 1'b0;
         s1_flash_rgb <= COLOUR_BLACK;
         s1_border    <= 1'b0;
         s1_ball      <= 1'b0;
         s1_paddle    <= 1'b0;
         s1_live      <= '0;
      end else begin
         s1_off       <= (hcount > SCR_R) || (vcount > SCR_B);
         s1_flash     <= flash_active;
         s1_flash_rgb <= flash_rgb;
         s1_border    <= (hcount < BRD_L) || (hcount > BRD_R) || (vcount < BRD_T);
         s1_ball      <= ball_hit;
         s1_paddle    <= (vcount >= PAD_TOP) && (vcount <= PAD_BOT) &&
                         (hcount >= left_position) && (hcount <= right_position);
         s1_live      <= blk_live;
      end
   end

   // x & -x isolates the lowest live slot, so at most one block_en bit is ever set
   always_comb begin
      rgb_d    = COLOUR_BLACK;
      player_d = 1'b0;
      block_d  = '0;
      if (s1_off) begin
         rgb_d = COLOUR_GREEN;
      end else if (s1_flash) begin
         rgb_d = s1_flash_rgb;
      end else if (s1_border) begin
         rgb_d = COLOUR_GREEN;
      end else if (s1_ball) begin
         rgb_d = COLOUR_WHITE;
      end else if (s1_paddle) begin
         rgb_d    = COLOUR_RED;
         player_d = 1'b1;
      end else if (|s1_live) begin
         rgb_d   = COLOUR_WHITE;
         block_d = s1_live & (~s1_live + N_BLOCKS'(1));
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rgb       <= 3'b000;
         player_en <= 1'b0;
         block_en  <= '0;
      end else begin
         rgb       <= rgb_d;
         player_en <= player_d;
         block_en  <= block_d;
      end
   end

endmodule

// File: tb/tb_display_render.sv
// Scoreboard bench for display_render: stimulus pushes hand-computed pixels, a negedge
// monitor pops them two clocks later. Flash checks follow DISPLAY_RENDER_FLASH_EN.
module tb_display_render;

   localparam int CW = 10;
   localparam int NB = 3;
   localparam int NK = 13;
   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] WHITE = 3'b111;
   localparam logic [2:0] RED   = 3'b100;
   localparam logic [2:0] GREEN = 3'b010;

   logic               clk = 1'b0;
   logic               reset_n;
   logic [CW-1:0]      hcount, vcount;
   logic               vsync;
   logic [NB*CW-1:0]   ball_x, ball_y;
   logic [CW-1:0]      left_position, right_position;
   logic               blk_wr;
   logic [4:0]         blk_idx;
   logic [CW-1:0]      blk_x0, blk_x1, blk_y0, blk_y1;
   logic [NK-1:0]      block_to_del;
   logic               win, lose;
   logic [2:0]         rgb;
   logic               player_en;
   logic [NK-1:0]      block_en;

   typedef struct {
      string         name;
      logic [2:0]    rgb;
      logic          pe;
      logic [NK-1:0] be;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;
   logic req      = 1'b0;
   logic pend_wr  = 1'b0;
   logic [1:0] pipe;

   display_render #(.N_BALLS(NB), .N_BLOCKS(NK), .BALL_R2(16), .CW(CW)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .hcount         (hcount),
      .vcount         (vcount),
      .vsync          (vsync),
      .ball_x         (ball_x),
      .ball_y         (ball_y),
      .left_position  (left_position),
      .right_position (right_position),
      .blk_wr         (blk_wr),
      .blk_idx        (blk_idx),
      .blk_x0         (blk_x0),
      .blk_x1         (blk_x1),
      .blk_y0         (blk_y0),
      .blk_y1         (blk_y1),
      .block_to_del   (block_to_del),
      .win            (win),
      .lose           (lose),
      .rgb            (rgb),
      .player_en      (player_en),
      .block_en       (block_en)
   );

   always #5 clk = ~clk;

   // Two-cycle latency tracker; in-flight pixels are discarded by reset
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) pipe <= 2'b00;
      else          pipe <= {pipe[0], req};
   end

   task automatic checkOutput(input string name, input logic [2:0] e_rgb,
                              input logic e_pe, input logic [NK-1:0] e_be);
      n_checks++;
      if (rgb === e_rgb && player_en === e_pe && block_en === e_be) n_pass++;
      else $display("[TB] FAIL %s: got rgb=%0d player_en=%0d block_en=%h, expected rgb=%0d player_en=%0d block_en=%h",
                    name, rgb, player_en, block_en, e_rgb, e_pe, e_be);
   endtask

   always @(negedge clk) begin
      if (pipe[1]) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL scoreboard_underflow: got an output slot, expected queue entries 0");
         end else begin
            mon_e = sb.pop_front();
            checkOutput(mon_e.name, mon_e.rgb, mon_e.pe, mon_e.be);
         end
      end
   end

   task automatic applyStimulus(input string name, input int h, input int v,
                                input logic [2:0] e_rgb, input logic e_pe, input logic [NK-1:0] e_be);
      exp_t e;
      @(negedge clk);
      hcount  = CW'(h);
      vcount  = CW'(v);
      blk_wr  = pend_wr;
      pend_wr = 1'b0;
      e.name = name; e.rgb = e_rgb; e.pe = e_pe; e.be = e_be;
      sb.push_back(e);
      req = 1'b1;
      @(posedge clk);
      #1 blk_wr = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         req = 1'b0;
         @(posedge clk);
      end
   endtask

   task automatic writeBlock(input int idx, input int x0, input int x1, input int y0, input int y1);
      @(negedge clk);
      req = 1'b0;
      blk_idx = 5'(idx);
      blk_x0 = CW'(x0); blk_x1 = CW'(x1); blk_y0 = CW'(y0); blk_y1 = CW'(y1);
      blk_wr = 1'b1;
      @(posedge clk);
      #1 blk_wr = 1'b0;
   endtask

   task automatic vsyncFall();
      @(negedge clk); req = 1'b0; vsync = 1'b0;
      @(posedge clk);
      @(negedge clk); vsync = 1'b1;
      @(posedge clk);
   endtask

   task automatic setBall(input int i, input int x, input int y);
      ball_x[i*CW +: CW] = CW'(x);
      ball_y[i*CW +: CW] = CW'(y);
   endtask

   task automatic pulseReset(input string name);
      @(negedge clk);
      req = 1'b0;
      #2 reset_n = 1'b0;
      #1 checkOutput(name, BLACK, 1'b0, '0);
      sb.delete();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset_n = 1'b0; vsync = 1'b1; win = 1'b0; lose = 1'b0;
      hcount = '0; vcount = '0; ball_x = '0; ball_y = '0;
      left_position = CW'(200); right_position = CW'(260);
      blk_wr = 1'b0; blk_idx = '0; blk_x0 = '0; blk_x1 = '0; blk_y0 = '0; blk_y1 = '0;
      block_to_del = '0;
      setBall(0, 300, 300); setBall(1, 500, 200); setBall(2, 500, 250);
      repeat (2) @(posedge clk);
      @(negedge clk) checkOutput("reset_state", BLACK, 1'b0, '0);
      reset_n = 1'b1;
      idleCycles(2);

      applyStimulus("offscreen_h", 640, 100, GREEN, 0, '0);
      applyStimulus("offscreen_v", 100, 480, GREEN, 0, '0);
      applyStimulus("last_row",    100, 479, BLACK, 0, '0);
      applyStimulus("border_l",      7, 100, GREEN, 0, '0);
      applyStimulus("inside_l",      8, 100, BLACK, 0, '0);
      applyStimulus("inside_r",    631, 100, BLACK, 0, '0);
      applyStimulus("border_r",    632, 100, GREEN, 0, '0);
      applyStimulus("border_t",    100,   7, GREEN, 0, '0);
      applyStimulus("inside_t",    100,   8, BLACK, 0, '0);

      applyStimulus("ball_302_301", 302, 301, WHITE, 0, '0);
      applyStimulus("ball_dx3",     303, 300, WHITE, 0, '0);
      applyStimulus("ball_dx4",     304, 300, BLACK, 0, '0);
      applyStimulus("ball_dxm3",    297, 300, WHITE, 0, '0);
      applyStimulus("ball_dxm4",    296, 300, BLACK, 0, '0);
      applyStimulus("ball1",        502, 202, WHITE, 0, '0);

      applyStimulus("paddle_mid",   230, 444, RED,   1, '0);
      applyStimulus("paddle_tl",    200, 440, RED,   1, '0);
      applyStimulus("paddle_br",    260, 448, RED,   1, '0);
      applyStimulus("paddle_right", 261, 444, BLACK, 0, '0);
      applyStimulus("paddle_below", 230, 449, BLACK, 0, '0);

      applyStimulus("unwritten", 0 + 250, 105, BLACK, 0, '0);
      writeBlock(5, 220, 300, 100, 110);
      applyStimulus("blk5_hit",    250, 105, WHITE, 0, NK'(1) << 5);
      applyStimulus("blk5_x0",     220, 105, BLACK, 0, '0);
      applyStimulus("blk5_x1",     300, 105, BLACK, 0, '0);
      applyStimulus("blk5_y1",     250, 110, BLACK, 0, '0);
      applyStimulus("blk5_corner", 221, 101, WHITE, 0, NK'(1) << 5);
      block_to_del = NK'(1) << 5;
      applyStimulus("blk5_deleted", 250, 105, BLACK, 0, '0);
      block_to_del = '0;

      writeBlock(7, 140, 160, 140, 160);
      writeBlock(2, 140, 160, 140, 160);
      applyStimulus("overlap_2_7", 150, 150, WHITE, 0, NK'(1) << 2);
      block_to_del = NK'(1) << 2;
      applyStimulus("overlap_del2", 150, 150, WHITE, 0, NK'(1) << 7);
      block_to_del = '0;

      writeBlock(20, 380, 420, 380, 420);
      applyStimulus("idx_out_of_range", 400, 400, BLACK, 0, '0);
      blk_idx = 5'd9; blk_x0 = CW'(340); blk_x1 = CW'(360); blk_y0 = CW'(340); blk_y1 = CW'(360);
      pend_wr = 1'b1;
      applyStimulus("wr_same_cycle_old", 350, 350, BLACK, 0, '0);
      applyStimulus("wr_next_cycle_new", 350, 350, WHITE, 0, NK'(1) << 9);

      setBall(0, 230, 444);
      applyStimulus("ball_on_paddle", 230, 444, WHITE, 0, '0);
      setBall(0, 300, 300);

      applyStimulus("pre_reset_ball", 302, 301, WHITE, 0, '0);
      idleCycles(3);
      pulseReset("reset_async");
      @(posedge clk); #1 checkOutput("reset_rel_c1", BLACK, 1'b0, '0);
      @(posedge clk); #1 checkOutput("reset_rel_c2", WHITE, 1'b0, '0);
      applyStimulus("table_cleared", 250, 105, BLACK, 0, '0);

`ifdef DISPLAY_RENDER_FLASH_EN
      @(negedge clk); win = 1'b1; req = 1'b0;
      @(posedge clk);
      applyStimulus("flash_f0",        100, 100, BLACK, 0, '0);
      applyStimulus("flash_f0_border",   3, 100, BLACK, 0, '0);
      applyStimulus("flash_offscreen", 700, 100, GREEN, 0, '0);
      for (int f = 1; f <= 6; f++) begin
         vsyncFall();
         applyStimulus($sformatf("flash_win_f%0d", f), 100, 100,
                       (f >= 3 && f <= 5) ? WHITE : BLACK, 0, '0);
      end
      win = 1'b0;
      applyStimulus("flash_cleared_ball", 302, 301, WHITE, 0, '0);
      @(negedge clk); lose = 1'b1; req = 1'b0;
      @(posedge clk);
      vsyncFall();
      applyStimulus("flash_lose_f1", 100, 100, BLACK, 0, '0);
      vsyncFall(); vsyncFall();
      applyStimulus("flash_lose_f3", 100, 100, RED, 0, '0);
      applyStimulus("flash_lose_paddle", 230, 444, RED, 0, '0);
      win = 1'b1;
      applyStimulus("flash_win_over_lose", 100, 100, WHITE, 0, '0);
      win = 1'b0; lose = 1'b0;
      applyStimulus("flash_both_off", 100, 100, BLACK, 0, '0);
      @(negedge clk); win = 1'b1; req = 1'b0;
      @(posedge clk);
      vsyncFall(); vsyncFall(); vsyncFall();
      applyStimulus("flash_lit_pre_reset", 100, 100, WHITE, 0, '0);
      idleCycles(3);
      pulseReset("flash_reset_async");
      idleCycles(2);
      applyStimulus("flash_fsm_restart", 100, 100, BLACK, 0, '0);
      win = 1'b0;
`else
      win = 1'b1;
      applyStimulus("win_solid",      100, 100, WHITE, 0, '0);
      applyStimulus("win_over_border",  3, 100, WHITE, 0, '0);
      applyStimulus("win_offscreen",  700, 100, GREEN, 0, '0);
      lose = 1'b1;
      applyStimulus("win_over_lose",  100, 100, WHITE, 0, '0);
      win = 1'b0;
      applyStimulus("lose_solid",     100, 100, RED,   0, '0);
      applyStimulus("lose_paddle",    230, 444, RED,   0, '0);
      lose = 1'b0;
      applyStimulus("result_cleared", 302, 301, WHITE, 0, '0);
`endif

      idleCycles(4);
      n_checks++;
      if (sb.size() == 0) n_pass++;
      else $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
